// File: rtl/fft_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package  : fft_pkg                                                          |
// | Purpose  : Shared frame geometry, output-FSM state type and the bit-reverse |
// |            helper used by the FFT input loader and its frame banks.         |
// | Contents : CPLX_W   - complex sample width ([63:32] re fp32, [31:0] im fp32)|
// |            N_POINTS - complex samples per frame (power of 2)                |
// |            LOG2N    - slot address width                                    |
// |            out_state_e - presentation FSM states (IDLE, HOLD)               |
// |            bitrev() - reverse the LOG2N address bits                        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package fft_pkg;

   localparam int unsigned CPLX_W   = 64;
   localparam int unsigned N_POINTS = 32;
   localparam int unsigned LOG2N    = $clog2(N_POINTS);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } out_state_e;

   // Slot index for decimation-in-time ordering: bit b of the result is bit
   // (LOG2N-1-b) of the sample index.
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < LOG2N; b++) begin
         r[b] = k[LOG2N-1-b];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fft_frame_bank                                                   |
// | Purpose  : One frame of DEPTH x WIDTH sample registers. A single write port |
// |            updates one slot per cycle; every slot is visible at once on a   |
// |            flat read vector (slot i at [i*WIDTH +: WIDTH]).                 |
// |            Contents have no reset: a frame is only ever read after all of   |
// |            its slots have been written.                                     |
// | Ports    : clk      in   1             rising-edge clock                   |
// |            we_i     in   1             write enable                         |
// |            waddr_i  in   ADDR_W        slot to write                        |
// |            wdata_i  in   WIDTH         sample to write                      |
// |            rdata_o  out  DEPTH*WIDTH   all slots, flattened                 |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int unsigned DEPTH  = N_POINTS,
   parameter int unsigned WIDTH  = CPLX_W,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   we_i,
   input  logic [ADDR_W-1:0]      waddr_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [DEPTH*WIDTH-1:0] rdata_o
);

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [WIDTH-1:0] slot_q;

      always_ff @(posedge clk) begin
         if (we_i && (waddr_i == ADDR_W'(g))) begin
            slot_q <= wdata_i;
         end
      end

      assign rdata_o[g*WIDTH +: WIDTH] = slot_q;
   end

endmodule
`default_nettype wire

// File: rtl/fft_input_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fft_input_loader                                                 |
// | Purpose  : Ping-pong frame collector feeding the radix-2 MAC butterfly      |
// |            stage. Samples fill one bank while the other is presented on     |
// |            inpmac for HOLD_CYCLES cycles (one MAC-select sweep). The source |
// |            is stalled only while both banks hold complete frames.           |
// | Config   : FFT_BITREV_EN - when defined, sample k lands in slot bitrev(k)   |
// |            (decimation-in-time order); otherwise slot k. Handshake, counters|
// |            and timing are identical in both builds.                         |
// | Ports    : clk          in   1                  rising-edge clock          |
// |            reset        in   1                  synchronous, active-low    |
// |            s_valid      in   1                  source sample valid        |
// |            s_ready      out  1                  loader can accept          |
// |            s_data       in   CPLX_W             complex sample             |
// |            s_last       in   1                  source end-of-frame marker |
// |            inpmac       out  N_POINTS*CPLX_W    presented frame (0 if idle)|
// |            frame_valid  out  1                  inpmac holds a frame       |
// |            frame_start  out  1                  first hold cycle pulse     |
// |            err_framing  out  1                  sticky s_last mismatch     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module fft_input_loader
   import fft_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [CPLX_W-1:0]          s_data,
   input  logic                       s_last,
   output logic [N_POINTS*CPLX_W-1:0] inpmac,
   output logic                       frame_valid,
   output logic                       frame_start,
   output logic                       err_framing
);

   localparam int unsigned      HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [LOG2N-1:0] LAST_SLOT = LOG2N'(N_POINTS - 1);
   localparam logic [HC_W-1:0]  LAST_HOLD = HC_W'(HOLD_CYCLES - 1);

   // Write side
   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
   logic             wr_bank_q, wr_bank_d;
   logic [1:0]       full_q, full_d;
   logic             err_q, err_d;

   // Presentation side
   out_state_e       state_q;
   logic             rd_bank_q;
   logic [HC_W-1:0]  hold_cnt_q;
   logic             frame_valid_q;
   logic             frame_start_q;

   logic             accept;
   logic             at_last_slot;
   logic             frame_done;
   logic             hold_end;
   logic [LOG2N-1:0] wr_addr;
   logic [1:0]       bank_we;
   logic [N_POINTS*CPLX_W-1:0] bank_rdata [2];

   assign s_ready      = !(full_q[0] && full_q[1]);
   assign accept       = s_valid && s_ready;
   assign at_last_slot = (wr_cnt_q == LAST_SLOT);
   assign frame_done   = accept && at_last_slot;
   assign hold_end     = (state_q == HOLD) && (hold_cnt_q == LAST_HOLD);

`ifdef FFT_BITREV_EN
   assign wr_addr = bitrev(wr_cnt_q);
`else
   assign wr_addr = wr_cnt_q;
`endif

   // Next-state for the write side. The release of the held bank is applied
   // before the fill-complete set so that a same-cycle free and fill are both
   // honoured, and the bank pointer then moves to whichever bank is free.
   always_comb begin
      // N_POINTS is a power of 2, so the counter wraps to slot 0 by itself.
      wr_cnt_d = accept ? (wr_cnt_q + 1'b1) : wr_cnt_q;

      full_d = full_q;
      if (hold_end) begin
         full_d[rd_bank_q] = 1'b0;
      end
      if (frame_done) begin
         full_d[wr_bank_q] = 1'b1;
      end

      // Stay on a full bank only while the other is also full (stall); the
      // pointer advances as soon as the held bank is released.
      wr_bank_d = wr_bank_q;
      if (full_d[wr_bank_q] && !full_d[~wr_bank_q]) begin
         wr_bank_d = ~wr_bank_q;
      end

      // The sample count defines the frame; s_last is only cross-checked.
      err_d = err_q | (accept && (s_last != at_last_slot));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_cnt_q  <= '0;
         wr_bank_q <= 1'b0;
         full_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         wr_cnt_q  <= wr_cnt_d;
         wr_bank_q <= wr_bank_d;
         full_q    <= full_d;
         err_q     <= err_d;
      end
   end

   // Presentation FSM. It looks at full_d so a frame is shown on the cycle
   // right after the accept that completed it, and a queued frame follows a
   // finished hold with no idle cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         rd_bank_q     <= 1'b0;
         hold_cnt_q    <= '0;
         frame_valid_q <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               frame_start_q <= 1'b0;
               if (full_d != 2'b00) begin
                  // Only one bank can complete while idle.
                  state_q       <= HOLD;
                  rd_bank_q     <= full_d[0] ? 1'b0 : 1'b1;
                  hold_cnt_q    <= '0;
                  frame_valid_q <= 1'b1;
                  frame_start_q <= 1'b1;
               end
            end
            HOLD: begin
               if (hold_end) begin
                  hold_cnt_q <= '0;
                  if (full_d[~rd_bank_q]) begin
                     rd_bank_q     <= ~rd_bank_q;
                     frame_start_q <= 1'b1;
                  end else begin
                     state_q       <= IDLE;
                     frame_valid_q <= 1'b0;
                     frame_start_q <= 1'b0;
                  end
               end else begin
                  hold_cnt_q    <= hold_cnt_q + 1'b1;
                  frame_start_q <= 1'b0;
               end
            end
            default: begin
               state_q       <= IDLE;
               frame_valid_q <= 1'b0;
               frame_start_q <= 1'b0;
            end
         endcase
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign bank_we[b] = accept && (wr_bank_q == 1'(b));

      fft_frame_bank #(
         .DEPTH  (N_POINTS),
         .WIDTH  (CPLX_W),
         .ADDR_W (LOG2N)
      ) u_bank (
         .clk     (clk),
         .we_i    (bank_we[b]),
         .waddr_i (wr_addr),
         .wdata_i (s_data),
         .rdata_o (bank_rdata[b])
      );
   end

   assign inpmac      = frame_valid_q ? bank_rdata[rd_bank_q] : '0;
   assign frame_valid = frame_valid_q;
   assign frame_start = frame_start_q;
   assign err_framing = err_q;

endmodule
`default_nettype wire
